// File: rtl/cache_way_select.sv
// Tag lookup and way allocation stage in front of a 4-way LRU tracker (2048 sets).
// Clears every tag valid bit after reset, then resolves one lookup at a time.
module cache_way_select #(
   parameter int ADDR_W   = 26,
   parameter int OFFSET_W = 4,
   parameter int TAG_W    = 11
) (
   input  logic                   main_clk,
   input  logic                   main_rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [ADDR_W-1:0]      req_addr,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic                   resp_hit,
   output logic [1:0]             resp_way,
   output logic                   resp_evict_valid,
   output logic [TAG_W-1:0]       resp_evict_tag,
   output logic [10:0]            tag_rd_addr,
   input  logic [4*(TAG_W+1)-1:0] tag_rd_data,
   output logic                   tag_wr_en,
   output logic [10:0]            tag_wr_addr,
   output logic [3:0]             tag_wr_way_mask,
   output logic [TAG_W:0]         tag_wr_data,
   output logic [10:0]            lru_addr,
   output logic [1:0]             lru_used_index,
   output logic                   lru_enable_write,
   input  logic [1:0]             lru_least_used_index,
   output logic                   init_done
);

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_IDLE   = 2'd1,
      ST_LOOKUP = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [11:0]        init_cnt_r;
   logic [10:0]        idx_r;
   logic [TAG_W-1:0]   tag_r;
   logic [10:0]        req_idx_s;
   logic [TAG_W-1:0]   req_tag_s;
   logic               offset_unused_s;
   logic [3:0]         match_s;
   logic [3:0]         inv_s;
   logic [TAG_W:0]     victim_entry_s;
   logic               look_hit_s;
   logic [1:0]         look_way_s;
   logic               look_evict_s;
   logic [TAG_W-1:0]   look_evict_tag_s;

   function automatic logic [TAG_W:0] get_entry(input logic [4*(TAG_W+1)-1:0] d,
                                                input logic [1:0] w);
      int unsigned base;
      base = 32'(w) * 32'(TAG_W + 1);
      return d[base +: TAG_W+1];
   endfunction

   function automatic logic [1:0] lowest_set(input logic [3:0] v);
      logic [1:0] r;
      casez (v)
         4'b???1: r = 2'd0;
         4'b??10: r = 2'd1;
         4'b?100: r = 2'd2;
         4'b1000: r = 2'd3;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] one_hot(input logic [1:0] w);
      return 4'b0001 << w;
   endfunction

   assign req_idx_s       = req_addr[OFFSET_W+10:OFFSET_W];
   assign req_tag_s       = req_addr[ADDR_W-1:OFFSET_W+11];
   assign offset_unused_s = ^req_addr[OFFSET_W-1:0];

   // Read ports follow the live request in IDLE so data is ready in LOOKUP
   assign tag_rd_addr = (state_r == ST_IDLE) ? req_idx_s : idx_r;
   assign lru_addr    = (state_r == ST_IDLE) ? req_idx_s : idx_r;

   // Per-way tag match and hit / allocation resolution
   always_comb begin
      match_s          = 4'b0000;
      inv_s            = 4'b0000;
      look_hit_s       = 1'b0;
      look_way_s       = 2'd0;
      look_evict_s     = 1'b0;
      look_evict_tag_s = {TAG_W{1'b0}};
      victim_entry_s   = get_entry(tag_rd_data, lru_least_used_index);
      for (int w = 0; w < 4; w++) begin
         match_s[w] = get_entry(tag_rd_data, 2'(w))[TAG_W] &&
                      (get_entry(tag_rd_data, 2'(w))[TAG_W-1:0] == tag_r);
         inv_s[w]   = ~get_entry(tag_rd_data, 2'(w))[TAG_W];
      end
      if (|match_s) begin
         look_hit_s = 1'b1;
         look_way_s = lowest_set(match_s);
      end else if (|inv_s) begin
         look_way_s = lowest_set(inv_s);
      end else begin
         look_way_s       = lru_least_used_index;
         look_evict_s     = 1'b1;
         look_evict_tag_s = victim_entry_s[TAG_W-1:0];
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_INIT: begin
            if (tag_wr_en && (tag_wr_addr == 11'd2047)) state_nxt_s = ST_IDLE;
            else                                         state_nxt_s = ST_INIT;
         end
         ST_IDLE: begin
            if (req_valid) state_nxt_s = ST_LOOKUP;
            else           state_nxt_s = ST_IDLE;
         end
         ST_LOOKUP: state_nxt_s = ST_RESP;
         ST_RESP: begin
            if (resp_ready) state_nxt_s = ST_IDLE;
            else            state_nxt_s = ST_RESP;
         end
         default: state_nxt_s = ST_INIT;
      endcase
   end

   // State, clear counter and captured request
   always_ff @(posedge main_clk or negedge main_rst_n) begin
      if (!main_rst_n) begin
         state_r    <= ST_INIT;
         init_cnt_r <= 12'd0;
         idx_r      <= 11'd0;
         tag_r      <= {TAG_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if ((state_r == ST_INIT) && !init_cnt_r[11]) init_cnt_r <= init_cnt_r + 12'd1;
         else                                          init_cnt_r <= init_cnt_r;
         if ((state_r == ST_IDLE) && req_valid) begin
            idx_r <= req_idx_s;
            tag_r <= req_tag_s;
         end else begin
            idx_r <= idx_r;
            tag_r <= tag_r;
         end
      end
   end

   // Registered outputs; write strobes fire on INIT sweep and on LOOKUP->RESP only
   always_ff @(posedge main_clk or negedge main_rst_n) begin
      if (!main_rst_n) begin
         req_ready        <= 1'b0;
         resp_valid       <= 1'b0;
         init_done        <= 1'b0;
         resp_hit         <= 1'b0;
         resp_way         <= 2'd0;
         resp_evict_valid <= 1'b0;
         resp_evict_tag   <= {TAG_W{1'b0}};
         tag_wr_en        <= 1'b0;
         tag_wr_addr      <= 11'd0;
         tag_wr_way_mask  <= 4'b0000;
         tag_wr_data      <= {(TAG_W+1){1'b0}};
         lru_enable_write <= 1'b0;
         lru_used_index   <= 2'd0;
      end else begin
         req_ready  <= (state_nxt_s == ST_IDLE);
         resp_valid <= (state_nxt_s == ST_RESP);
         init_done  <= init_done | (state_nxt_s == ST_IDLE) | (offset_unused_s & 1'b0);
         if ((state_r == ST_INIT) && !init_cnt_r[11]) begin
            tag_wr_en       <= 1'b1;
            tag_wr_addr     <= init_cnt_r[10:0];
            tag_wr_way_mask <= 4'b1111;
            tag_wr_data     <= {(TAG_W+1){1'b0}};
         end else if ((state_r == ST_LOOKUP) && !look_hit_s) begin
            tag_wr_en       <= 1'b1;
            tag_wr_addr     <= idx_r;
            tag_wr_way_mask <= one_hot(look_way_s);
            tag_wr_data     <= {1'b1, tag_r};
         end else begin
            tag_wr_en       <= 1'b0;
            tag_wr_addr     <= tag_wr_addr;
            tag_wr_way_mask <= 4'b0000;
            tag_wr_data     <= {(TAG_W+1){1'b0}};
         end
         if (state_r == ST_LOOKUP) begin
            lru_enable_write <= 1'b1;
            lru_used_index   <= look_way_s;
            resp_hit         <= look_hit_s;
            resp_way         <= look_way_s;
            resp_evict_valid <= look_evict_s;
            resp_evict_tag   <= look_evict_tag_s;
         end else begin
            lru_enable_write <= 1'b0;
            lru_used_index   <= lru_used_index;
            resp_hit         <= resp_hit;
            resp_way         <= resp_way;
            resp_evict_valid <= resp_evict_valid;
            resp_evict_tag   <= resp_evict_tag;
         end
      end
   end

endmodule
